// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings and op width shared by the multiply/divide unit
package mdu_pkg;
  localparam int OP_W = 4;
  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_t;
endpackage

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: request (start/op/a/b) and result (busy/hi/lo) bundle between E stage and the multiply/divide unit
interface mdu_hilo_if #(parameter int WIDTH = 32);
  import mdu_pkg::*;
  logic start;
  logic [OP_W-1:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, a, b, input busy, hi, lo);
  modport slave(input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_core.sv
// mdu_core: combinational product/quotient/remainder datapath; ports op/a/b/hi/lo in, res_hi/res_lo/upd out (upd=0 on divide by zero)
module mdu_core import mdu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             upd
);
  logic [2*WIDTH-1:0] pu, ps, acc, res;
  logic [WIDTH-1:0] ma, mb, sd, ud, sq, sr, q_s, r_s, uq, ur;
  assign pu = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign ps = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign acc = {hi, lo};
  assign ma = a[WIDTH-1] ? -a : a;
  assign mb = b[WIDTH-1] ? -b : b;
  assign sd = (mb == '0) ? WIDTH'(1) : mb;
  assign ud = (b == '0) ? WIDTH'(1) : b;
  assign sq = ma / sd;
  assign sr = ma % sd;
  assign q_s = (a[WIDTH-1] ^ b[WIDTH-1]) ? -sq : sq;
  assign r_s = a[WIDTH-1] ? -sr : sr;
  assign uq = a / ud;
  assign ur = a % ud;
  assign res = (op == OP_MULT)  ? ps :
               (op == OP_MULTU) ? pu :
               (op == OP_DIV)   ? {r_s, q_s} :
               (op == OP_DIVU)  ? {ur, uq} :
               (op == OP_MADD)  ? acc + ps :
               (op == OP_MADDU) ? acc + pu :
               (op == OP_MSUB)  ? acc - ps : acc - pu;
  assign res_hi = res[2*WIDTH-1:WIDTH];
  assign res_lo = res[WIDTH-1:0];
  assign upd = !((op == OP_DIV || op == OP_DIVU) && b == '0);
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle mul/div unit owning HI/LO; ports clk, reset, bus (start/op/a/b in, busy/hi/lo out); MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
module mdu_hilo import mdu_pkg::*; #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_hilo_if.slave bus
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  typedef enum logic {S_IDLE, S_BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  op_t op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_r, lo_r, res_hi, res_lo;
  logic busy_r, upd, is_mul, is_div, is_madd, go;
  assign is_mul = bus.op == OP_MULT || bus.op == OP_MULTU;
  assign is_div = bus.op == OP_DIV || bus.op == OP_DIVU;
`ifdef MDU_MADD_EN
  assign is_madd = bus.op == OP_MADD || bus.op == OP_MADDU || bus.op == OP_MSUB || bus.op == OP_MSUBU;
`else
  assign is_madd = 1'b0;
`endif
  assign go = bus.start && (is_mul || is_madd || is_div);
  mdu_core #(.WIDTH(WIDTH)) u_core (
    .op(op_q), .a(a_q), .b(b_q), .hi(hi_r), .lo(lo_r),
    .res_hi(res_hi), .res_lo(res_lo), .upd(upd)
  );
  assign bus.busy = busy_r;
  assign bus.hi = hi_r;
  assign bus.lo = lo_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy_r <= 1'b0;
      cnt <= '0;
      hi_r <= '0;
      lo_r <= '0;
      op_q <= OP_NONE;
      a_q <= '0;
      b_q <= '0;
    end else if (state == S_IDLE) begin
      if (bus.start && bus.op == OP_MTHI) hi_r <= bus.a;
      if (bus.start && bus.op == OP_MTLO) lo_r <= bus.a;
      if (go) begin
        op_q <= op_t'(bus.op);
        a_q <= bus.a;
        b_q <= bus.b;
        cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        state <= S_BUSY;
        busy_r <= 1'b1;
      end
    end else if (cnt == CW'(1)) begin
      state <= S_IDLE;
      busy_r <= 1'b0;
      cnt <= '0;
      if (upd) begin
        hi_r <= res_hi;
        lo_r <= res_lo;
      end
    end else begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Parametrised multiply/divide unit that owns the architectural HI/LO register pair for the pipelined MIPS core.
- Supersedes the fixed combinational high-half generation. It adds the following:
  - multi-cycle signed/unsigned multiply and divide;
  - direct HI/LO writes;
  - a busy handshake that the hazard unit uses for stalling.
- Sits in the E stage. Results are read by mfhi/mflo via the `hi`/`lo` ports.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for multiply-class ops (must be >= 1).
- DIV_CYCLES, 10, busy cycles for divide-class ops (must be >= 1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  op request valid this cycle.
- op  in  4  operation code (see Decomposition).
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- busy  out  1  computation in flight (registered).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: at a clk edge with reset=1, the following all take effect:
  - hi=0, lo=0, busy=0, state=IDLE, counter=0;
  - any in-flight op is aborted with no HI/LO update.
- States: IDLE, BUSY.
- IDLE, start=1, op MTHI: hi<=a at this edge. lo is unchanged, busy stays 0, one cycle.
- IDLE, start=1, op MTLO: lo<=a at this edge. hi is unchanged, busy stays 0.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - a and b are latched at edge t;
  - counter is loaded with N (MULT_CYCLES or DIV_CYCLES);
  - state goes to BUSY and busy=1 after edge t.
- BUSY: the counter decrements each edge. At edge t+N:
  - hi/lo take the result;
  - busy returns to 0;
  - state returns to IDLE.
  - busy is therefore high for exactly N cycles.
- start while BUSY: ignored entirely. The hazard unit must stall on (start | busy); the block does not combine them.
- op NONE or an unused code with start=1: no effect.
- MULT: {hi,lo} = signed a*b, 2*WIDTH bits. MULTU: the same, unsigned.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b=0): the op still takes DIV_CYCLES, and hi/lo are left unchanged at completion.
- Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0.
- Reset mid-BUSY: aborts the op, clears hi/lo, busy=0 at that edge.
- hi/lo outputs are the registers directly; there is no read-port latency.

Optional Feature:
- Macro: MDU_MADD_EN.
- With the macro defined:
  - ops MADD/MADDU/MSUB/MSUBU are accepted;
  - each computes {hi,lo} +/- (a*b), signed or unsigned, with the 2*WIDTH sum wrapping;
  - each takes MULT_CYCLES;
  - the value of {hi,lo} used is the one captured at the start edge.
- Without the macro: these four codes behave as NONE (no effect, busy stays 0).

Decomposition:
- Shared package mdu_pkg contains the following:
  - op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10;
  - the op width constant (4).
- One sub-module: mdu_core. It is the combinational product/quotient/remainder datapath fed from the latched operands.
- The top level holds the FSM, counter and HI/LO registers.

Test Plan:
- Reset, then MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0 after each edge; busy never asserts.
- MULT a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- DIV b=0 following hi=0xAAAA0000, lo=0x5555 -> busy for 10 cycles, then hi/lo unchanged. DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT started, then start=1 MTHI on busy cycle 2, then reset on cycle 3 -> the MTHI is ignored; at the reset edge, busy=0, hi=lo=0; no later update occurs.
- MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0 after 5 cycles. Macro undefined: the same op -> no change, busy stays 0.
